game_sequencer: RTL and testbench

//   Turn controller for the tic-tac-toe board. Owns the 9-cell board registers
//   and feeds them to boxSelector (out0..out8) and the display. Takes the

---
 rtl/game_sequencer.sv | 174 +++++++++++++++++
 tb/tb_game_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Tic-tac-toe turn controller: owns the 9-cell board, validates cursor
// placements, checks the 8 win lines after every legal move, alternates turns
// and latches a terminal WIN or DRAW state until reset.
module game_sequencer #(
  parameter logic [1:0]  FIRST_PLAYER = 2'b01,
  parameter int unsigned ERR_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       place,
  input  logic [3:0] curBox,
  output logic [1:0] out0,
  output logic [1:0] out1,
  output logic [1:0] out2,
  output logic [1:0] out3,
  output logic [1:0] out4,
  output logic [1:0] out5,
  output logic [1:0] out6,
  output logic [1:0] out7,
  output logic [1:0] out8,
  output logic [1:0] player,
  output logic [1:0] winner,
  output logic       gameOver,
  output logic       draw,
  output logic       illegal,
  output logic [3:0] moveCount
);

  // Any FIRST_PLAYER other than 2'b10 behaves as player 1.
  localparam logic [1:0] FirstMark = (FIRST_PLAYER == 2'b10) ? 2'b10 : 2'b01;
  localparam int unsigned ErrW = $clog2(ERR_CYCLES + 1);
  localparam logic [ErrW-1:0] ErrLoad = ErrW'(ERR_CYCLES);
  localparam logic [3:0] MaxMoves = 4'd9;

  typedef enum logic [1:0] {StPlay, StCheck, StWin, StDraw} state_e;

  state_e            state_q, state_d;
  logic [8:0][1:0]   board_q, board_d;
  logic [1:0]        player_q, player_d;
  logic [1:0]        winner_q, winner_d;
  logic              game_over_q, game_over_d;
  logic              draw_q, draw_d;
  logic              illegal_q, illegal_d;
  logic [3:0]        move_cnt_q, move_cnt_d;
  logic [ErrW-1:0]   err_cnt_q, err_cnt_d;

  logic              box_valid;
  logic              box_empty;

  // True when mark m owns any complete row, column or diagonal of b.
  function automatic logic has_line(input logic [8:0][1:0] b, input logic [1:0] m);
    logic [8:0] own;
    for (int i = 0; i < 9; i++) begin
      own[i] = (b[i] == m);
    end
    return (own[0] & own[1] & own[2]) | (own[3] & own[4] & own[5]) |
           (own[6] & own[7] & own[8]) | (own[0] & own[3] & own[6]) |
           (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
           (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
  endfunction

  // Decode the cursor: in range and pointing at an empty cell.
  always_comb begin
    box_valid = (curBox <= 4'd8);
    box_empty = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (curBox == 4'(i)) begin
        box_empty = (board_q[i] == 2'b00);
      end
    end
  end

  // Next-state logic for the turn FSM, board and status outputs.
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    player_d    = player_q;
    winner_d    = winner_q;
    game_over_d = game_over_q;
    draw_d      = draw_q;
    move_cnt_d  = move_cnt_q;
    // Rejected-move indicator times out on its own in every state.
    err_cnt_d   = (err_cnt_q != '0) ? err_cnt_q - 1'b1 : err_cnt_q;

    unique case (state_q)
      StPlay: begin
        if (place) begin
          if (box_valid && box_empty) begin
            for (int i = 0; i < 9; i++) begin
              if (curBox == 4'(i)) begin
                board_d[i] = player_q;
              end
            end
            if (move_cnt_q != MaxMoves) begin
              move_cnt_d = move_cnt_q + 4'd1;
            end
            err_cnt_d = '0;
            state_d   = StCheck;
          end else begin
            // Reload restarts the window even if already flagged.
            err_cnt_d = ErrLoad;
          end
        end
      end
      StCheck: begin
        // Only the mover can have just completed a line; a win outranks a full board.
        if (has_line(board_q, player_q)) begin
          winner_d    = player_q;
          game_over_d = 1'b1;
          player_d    = 2'b00;
          state_d     = StWin;
        end else if (move_cnt_q == MaxMoves) begin
          draw_d      = 1'b1;
          game_over_d = 1'b1;
          player_d    = 2'b00;
          state_d     = StDraw;
        end else begin
          player_d = (player_q == 2'b01) ? 2'b10 : 2'b01;
          state_d  = StPlay;
        end
      end
      StWin, StDraw: begin
        state_d = state_q;
      end
      default: begin
        state_d = StPlay;
      end
    endcase

    illegal_d = (err_cnt_d != '0);
  end

  // State and registered outputs; reset is immediate and asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StPlay;
      board_q     <= '0;
      player_q    <= FirstMark;
      winner_q    <= 2'b00;
      game_over_q <= 1'b0;
      draw_q      <= 1'b0;
      illegal_q   <= 1'b0;
      move_cnt_q  <= 4'd0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      player_q    <= player_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      draw_q      <= draw_d;
      illegal_q   <= illegal_d;
      move_cnt_q  <= move_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out0      = board_q[0];
  assign out1      = board_q[1];
  assign out2      = board_q[2];
  assign out3      = board_q[3];
  assign out4      = board_q[4];
  assign out5      = board_q[5];
  assign out6      = board_q[6];
  assign out7      = board_q[7];
  assign out8      = board_q[8];
  assign player    = player_q;
  assign winner    = winner_q;
  assign gameOver  = game_over_q;
  assign draw      = draw_q;
  assign illegal   = illegal_q;
  assign moveCount = move_cnt_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: wins, draws, illegal moves, CHECK-cycle
// placement, terminal freeze and asynchronous reset for both first-player settings.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       place = 1'b0;
  logic [3:0] cur_box = 4'd0;

  logic [1:0] o0, o1, o2, o3, o4, o5, o6, o7, o8;
  logic [1:0] player, winner;
  logic       game_over, draw, illegal;
  logic [3:0] move_count;

  logic [1:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
  logic [1:0] b_player, b_winner;
  logic       b_game_over, b_draw, b_illegal;
  logic [3:0] b_move_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  game_sequencer #(.FIRST_PLAYER(2'b01), .ERR_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .place(place), .curBox(cur_box),
    .out0(o0), .out1(o1), .out2(o2), .out3(o3), .out4(o4),
    .out5(o5), .out6(o6), .out7(o7), .out8(o8),
    .player(player), .winner(winner), .gameOver(game_over), .draw(draw),
    .illegal(illegal), .moveCount(move_count)
  );

  game_sequencer #(.FIRST_PLAYER(2'b10), .ERR_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .place(place), .curBox(cur_box),
    .out0(b0), .out1(b1), .out2(b2), .out3(b3), .out4(b4),
    .out5(b5), .out6(b6), .out7(b7), .out8(b8),
    .player(b_player), .winner(b_winner), .gameOver(b_game_over), .draw(b_draw),
    .illegal(b_illegal), .moveCount(b_move_count)
  );

  function automatic logic [17:0] board_a();
    return {o8, o7, o6, o5, o4, o3, o2, o1, o0};
  endfunction

  function automatic logic [17:0] board_b();
    return {b8, b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Synchronous-looking reset: asserted between edges, released on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle place pulse; returns at the falling edge right after the sampling edge.
  task automatic pulse(input logic [3:0] box);
    @(negedge clk);
    cur_box = box;
    place   = 1'b1;
    @(negedge clk);
    place   = 1'b0;
  endtask

  // Full move: pulse plus the CHECK cycle.
  task automatic move(input logic [3:0] box);
    pulse(box);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_board", 32'(board_a()), 32'h0);
    chk("rst_player", 32'(player), 32'h1);
    chk("rst_player_b", 32'(b_player), 32'h2);
    chk("rst_flags", 32'({winner, game_over, draw, illegal, move_count}), 32'h0);
    reset = 1'b0;

    // 1: row 0-1-2 win for player 1
    move(4'd0); move(4'd3); move(4'd1); move(4'd4);
    pulse(4'd2);
    chk("t1_write_before_check", 32'(winner), 32'h0);
    @(negedge clk);
    chk("t1_board", 32'(board_a()),
        32'({2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01}));
    chk("t1_winner", 32'(winner), 32'h1);
    chk("t1_over", 32'({game_over, draw}), 32'h2);
    chk("t1_player", 32'(player), 32'h0);
    chk("t1_count", 32'(move_count), 32'd5);
    move(4'd5);
    chk("t1_frozen_board", 32'(board_a()),
        32'({2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01}));
    chk("t1_frozen_count", 32'(move_count), 32'd5);
    chk("t1_frozen_illegal", 32'(illegal), 32'h0);

    // 2: occupied cell rejected, illegal window length and restart
    do_reset();
    pulse(4'd4);
    chk("t2_latency_cell", 32'(o4), 32'h1);
    chk("t2_latency_player", 32'(player), 32'h1);
    chk("t2_latency_count", 32'(move_count), 32'd1);
    @(negedge clk);
    chk("t2_toggle", 32'(player), 32'h2);
    pulse(4'd4);
    chk("t2_ill_c1", 32'(illegal), 32'h1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("t2_ill_c%0d", i), 32'(illegal), 32'h1);
    end
    @(negedge clk);
    chk("t2_ill_off", 32'(illegal), 32'h0);
    chk("t2_state", 32'({o4, player, move_count}), 32'({2'b01, 2'b10, 4'd1}));
    pulse(4'd4);
    @(negedge clk);
    @(negedge clk);
    pulse(4'd4);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("t2_restart_c%0d", i), 32'(illegal), 32'h1);
    end
    @(negedge clk);
    chk("t2_restart_off", 32'(illegal), 32'h0);

    // 3: out-of-range cursor
    do_reset();
    pulse(4'd9);
    chk("t3_ill9", 32'(illegal), 32'h1);
    repeat (4) @(negedge clk);
    chk("t3_ill9_off", 32'(illegal), 32'h0);
    pulse(4'd15);
    chk("t3_ill15", 32'(illegal), 32'h1);
    chk("t3_board", 32'(board_a()), 32'h0);
    chk("t3_count_player", 32'({move_count, player}), 32'({4'd0, 2'b01}));

    // 4a: full board without a line
    do_reset();
    move(4'd0); move(4'd1); move(4'd2); move(4'd4); move(4'd3);
    move(4'd5); move(4'd7); move(4'd6); move(4'd8);
    chk("t4_board", 32'(board_a()),
        32'({2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01}));
    chk("t4_draw", 32'({game_over, draw}), 32'h3);
    chk("t4_winner", 32'(winner), 32'h0);
    chk("t4_count", 32'(move_count), 32'd9);
    chk("t4_player", 32'(player), 32'h0);

    // 4b: ninth move completes column 0-3-6
    do_reset();
    move(4'd0); move(4'd1); move(4'd2); move(4'd4); move(4'd3);
    move(4'd5); move(4'd7); move(4'd8); move(4'd6);
    chk("t4b_winner", 32'(winner), 32'h1);
    chk("t4b_flags", 32'({game_over, draw}), 32'h2);
    chk("t4b_count", 32'(move_count), 32'd9);

    // 5: second place lands in CHECK and is ignored
    do_reset();
    @(negedge clk);
    cur_box = 4'd0;
    place   = 1'b1;
    @(negedge clk);
    cur_box = 4'd1;
    @(negedge clk);
    place   = 1'b0;
    @(negedge clk);
    chk("t5_board", 32'(board_a()), 32'h1);
    chk("t5_count", 32'(move_count), 32'd1);
    chk("t5_illegal", 32'(illegal), 32'h0);
    chk("t5_player", 32'(player), 32'h2);

    // 6: asynchronous reset mid-game, both first-player settings
    do_reset();
    move(4'd0); move(4'd1); move(4'd2);
    chk("t6_b_first_mark", 32'(b0), 32'h2);
    chk("t6_pre_count", 32'(move_count), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("t6_board", 32'(board_a()), 32'h0);
    chk("t6_flags", 32'({winner, game_over, draw, illegal, move_count}), 32'h0);
    chk("t6_player", 32'(player), 32'h1);
    chk("t6_b_board", 32'(board_b()), 32'h0);
    chk("t6_b_count", 32'(b_move_count), 32'd0);
    chk("t6_b_player", 32'(b_player), 32'h2);
    @(negedge clk);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
